// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches and
// registers instruction, PC and IF exception vector into the IF/ID boundary.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_PC   = 32'h0000_0080,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_stall,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch,
  input  logic [27:0] offset28,
  input  logic [31:0] rs,
  input  logic        exc_req,
  input  logic        rfe_req,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  output logic        ins_valid,
  output logic [4:0]  vector_if
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic [31:0] skid_ins;
  logic        skid_err;
  logic        started;
  logic        halt;

  logic        redirect;
  logic [31:0] target;
  logic        slot_free;
  logic        misaligned;

  always_comb begin
    redirect = exc_req | rfe_req | (pc_src != 2'b00);
    target   = pc + 32'd4;
    if (exc_req)      target = EXC_PC;
    else if (rfe_req) target = epc;
    else begin
      case (pc_src)
        2'b01:   target = branch;
        2'b10:   target = {pc_out[31:28], offset28};
        2'b11:   target = rs;
        default: target = pc + 32'd4;
      endcase
    end
  end

  assign slot_free  = !ins_valid || !id_stall;
  assign misaligned = (pc[1:0] != 2'b00);

  // DROP keeps presenting the abandoned address until its ack arrives,
  // while pc already holds the redirect target.
  assign imem_req  = ((state == FETCH) && started && !halt && !misaligned) ||
                     (state == DROP);
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      drop_addr <= '0;
      skid_ins  <= '0;
      skid_err  <= 1'b0;
      started   <= 1'b0;
      halt      <= 1'b0;
      ins_out   <= NOP_INS;
      pc_out    <= '0;
      ins_valid <= 1'b0;
      vector_if <= '0;
    end else begin
      started <= 1'b1;

      // Consumed slot empties; any later load below overrides this.
      if (ins_valid && !id_stall) begin
        ins_valid <= 1'b0;
        ins_out   <= NOP_INS;
        vector_if <= '0;
      end

      if (redirect) begin
        ins_valid <= 1'b0;
        ins_out   <= NOP_INS;
        vector_if <= '0;
        pc        <= target;
        halt      <= 1'b0;
      end

      case (state)
        FETCH: begin
          if (redirect) begin
            if (imem_req && !imem_ack) begin
              state     <= DROP;
              drop_addr <= pc;
            end
          end else if (imem_req && imem_ack) begin
            if (slot_free) begin
              ins_valid <= 1'b1;
              pc_out    <= pc;
              if (imem_err) begin
                ins_out   <= NOP_INS;
                vector_if <= 5'd5;
                halt      <= 1'b1;
              end else begin
                ins_out   <= imem_rdata;
                vector_if <= '0;
                pc        <= pc + 32'd4;
              end
            end else begin
              skid_ins <= imem_rdata;
              skid_err <= imem_err;
              state    <= HOLD;
            end
          end else if (started && !halt && misaligned && slot_free) begin
            ins_valid <= 1'b1;
            ins_out   <= NOP_INS;
            pc_out    <= pc;
            vector_if <= 5'd4;
            halt      <= 1'b1;
          end
        end

        HOLD: begin
          if (redirect) begin
            state <= FETCH;
          end else if (!id_stall) begin
            state     <= FETCH;
            ins_valid <= 1'b1;
            pc_out    <= pc;
            if (skid_err) begin
              ins_out   <= NOP_INS;
              vector_if <= 5'd5;
              halt      <= 1'b1;
            end else begin
              ins_out   <= skid_ins;
              vector_if <= '0;
              pc        <= pc + 32'd4;
            end
          end
        end

        DROP: begin
          if (imem_ack) state <= FETCH;
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by a randomized run checked
// against an expected instruction-stream model.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        id_stall;
  logic [1:0]  pc_src;
  logic [31:0] branch;
  logic [27:0] offset28;
  logic [31:0] rs;
  logic        exc_req;
  logic        rfe_req;
  logic [31:0] epc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] ins_out;
  logic [31:0] pc_out;
  logic        ins_valid;
  logic [4:0]  vector_if;

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .EXC_PC  (32'h0000_0080),
    .NOP_INS (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .id_stall  (id_stall),
    .pc_src    (pc_src),
    .branch    (branch),
    .offset28  (offset28),
    .rs        (rs),
    .exc_req   (exc_req),
    .rfe_req   (rfe_req),
    .epc       (epc),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .imem_err  (imem_err),
    .ins_out   (ins_out),
    .pc_out    (pc_out),
    .ins_valid (ins_valid),
    .vector_if (vector_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  int unsigned cnt;
  int unsigned delay;
  bit          rand_mode;
  bit          mem_manual;
  bit          err_next;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1111_0000 + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned next_delay();
    return rand_mode ? $urandom_range(0, 3) : delay;
  endfunction

  // Memory responder: answers each request after a configurable wait.
  task automatic step();
    @(posedge clk);
    #1;
    if (!mem_manual) begin
      if (imem_req) begin
        if (cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          imem_err   = err_next;
          cnt        = next_delay();
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = '0;
          imem_err   = 1'b0;
          cnt        = cnt - 1;
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        imem_err   = 1'b0;
        cnt        = next_delay();
      end
    end
  endtask

  task automatic clear_redirects();
    pc_src  = 2'b00;
    exc_req = 1'b0;
    rfe_req = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    id_stall = 1'b0;
    clear_redirects();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (imem_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed no imem_ack within 40 cycles, expected one", tag);
    end
  endtask

  // Random-phase model state
  logic [31:0] exp_pc;
  logic [31:0] tgt;
  logic [31:0] prev_ins;
  logic [31:0] prev_pc;
  logic [31:0] prev_addr;
  logic [4:0]  prev_vec;
  bit          prev_hold;
  bit          prev_redir;
  bit          prev_pend;
  bit          redir;
  int          n_cons;
  int unsigned r;

  initial begin
    n_cmp = 0; n_err = 0; cnt = 0; delay = 0;
    rand_mode = 1'b0; mem_manual = 1'b0; err_next = 1'b0;
    reset = 1'b1; id_stall = 1'b0; pc_src = 2'b00; branch = '0; offset28 = '0;
    rs = '0; exc_req = 1'b0; rfe_req = 1'b0; epc = '0;
    imem_ack = 1'b0; imem_rdata = '0; imem_err = 1'b0;

    // 1: reset state and zero-wait sequential stream
    delay = 0;
    do_reset();
    chk("rst_valid", ins_valid, 0);
    chk("rst_ins", ins_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_vec", vector_if, 0);
    chk("rst_req", imem_req, 0);
    step();
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_nvalid", ins_valid, 0);
    step();
    chk("t1_valid", ins_valid, 1);
    chk("t1_pc0", pc_out, 32'h0);
    chk("t1_ins0", ins_out, 32'h1111_0000);
    step();
    chk("t1_pc4", pc_out, 32'h4);
    step();
    chk("t1_pc8", pc_out, 32'h8);
    chk("t1_ins8", ins_out, 32'h1111_0008);

    // 2: word arrives while ID stalls -> skid and hold
    delay = 3;
    do_reset();
    wait_ack("t2_ack0");
    step();
    chk("t2_valid", ins_valid, 1);
    chk("t2_pc0", pc_out, 32'h0);
    id_stall = 1'b1;
    wait_ack("t2_ack1");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_hold_req", imem_req, 0);
      chk("t2_hold_valid", ins_valid, 1);
      chk("t2_hold_ins", ins_out, 32'h1111_0000);
      chk("t2_hold_pc", pc_out, 32'h0);
    end
    id_stall = 1'b0;
    step();
    chk("t2_skid_ins", ins_out, 32'h1111_0004);
    chk("t2_skid_pc", pc_out, 32'h4);
    chk("t2_skid_valid", ins_valid, 1);

    // 3: branch while request outstanding -> old word dropped
    delay = 3;
    do_reset();
    step();
    pc_src = 2'b01; branch = 32'h40;
    step();
    clear_redirects();
    chk("t3_drop_req", imem_req, 1);
    chk("t3_drop_addr", imem_addr, 32'h0);
    chk("t3_drop_valid", ins_valid, 0);
    wait_ack("t3_ack_old");
    step();
    chk("t3_new_addr", imem_addr, 32'h40);
    chk("t3_new_req", imem_req, 1);
    chk("t3_discard", ins_valid, 0);
    wait_ack("t3_ack_new");
    step();
    chk("t3_valid", ins_valid, 1);
    chk("t3_pc", pc_out, 32'h40);
    chk("t3_ins", ins_out, 32'h1111_0040);

    // 4: simultaneous exc/rfe/jr -> exception vector wins; then PC wrap
    delay = 0;
    do_reset();
    step();
    step();
    exc_req = 1'b1; rfe_req = 1'b1; pc_src = 2'b11; rs = 32'h200; epc = 32'h300;
    step();
    clear_redirects();
    chk("t4_squash", ins_valid, 0);
    chk("t4_addr", imem_addr, 32'h80);
    step();
    chk("t4_pc", pc_out, 32'h80);
    chk("t4_ins", ins_out, 32'h1111_0080);
    pc_src = 2'b11; rs = 32'hFFFF_FFFC;
    step();
    clear_redirects();
    step();
    chk("wrap_pc_top", pc_out, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc_zero", pc_out, 32'h0);
    chk("wrap_ins", ins_out, 32'h1111_0000);

    // 5: misaligned target, then fetch bus error
    delay = 0;
    do_reset();
    step();
    step();
    pc_src = 2'b11; rs = 32'h42;
    step();
    clear_redirects();
    chk("t5_squash", ins_valid, 0);
    chk("t5_noreq", imem_req, 0);
    step();
    chk("t5_mis_vec", vector_if, 4);
    chk("t5_mis_valid", ins_valid, 1);
    chk("t5_mis_pc", pc_out, 32'h42);
    chk("t5_mis_ins", ins_out, 32'h0);
    chk("t5_mis_noreq", imem_req, 0);
    step();
    chk("t5_wait_noreq", imem_req, 0);
    pc_src = 2'b01; branch = 32'h100; err_next = 1'b1;
    step();
    clear_redirects();
    step();
    err_next = 1'b0;
    chk("t5_err_vec", vector_if, 5);
    chk("t5_err_ins", ins_out, 32'h0);
    chk("t5_err_valid", ins_valid, 1);
    chk("t5_err_pc", pc_out, 32'h100);
    chk("t5_err_halt", imem_req, 0);

    // 6: reset during DROP; late ack ignored
    delay = 5;
    do_reset();
    step();
    pc_src = 2'b01; branch = 32'h40;
    step();
    clear_redirects();
    chk("t6_drop_req", imem_req, 1);
    mem_manual = 1'b1;
    imem_ack = 1'b0;
    reset = 1'b1;
    step();
    chk("t6_rst_valid", ins_valid, 0);
    chk("t6_rst_ins", ins_out, 32'h0);
    chk("t6_rst_pc", pc_out, 32'h0);
    chk("t6_rst_vec", vector_if, 0);
    chk("t6_rst_req", imem_req, 0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    reset = 1'b0;
    step();
    imem_ack = 1'b0; imem_rdata = '0;
    mem_manual = 1'b0;
    chk("t6_late_valid", ins_valid, 0);
    chk("t6_req", imem_req, 1);
    chk("t6_addr", imem_addr, 32'h0);

    // Randomized run: consumed instructions must follow the expected PC stream
    rand_mode = 1'b1;
    do_reset();
    exp_pc = 32'h0;
    n_cons = 0;
    prev_hold = 1'b0; prev_redir = 1'b0; prev_pend = 1'b0;
    prev_ins = '0; prev_pc = '0; prev_addr = '0; prev_vec = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (prev_hold) begin
        chk("r_hold_valid", ins_valid, 1);
        chk("r_hold_ins", ins_out, prev_ins);
        chk("r_hold_pc", pc_out, prev_pc);
        chk("r_hold_vec", vector_if, prev_vec);
      end
      if (prev_redir) chk("r_squash", ins_valid, 0);
      if (prev_pend) begin
        chk("r_req_held", imem_req, 1);
        chk("r_addr_stable", imem_addr, prev_addr);
      end

      clear_redirects();
      id_stall = ($urandom_range(0, 9) < 4);
      r = $urandom_range(0, 29);
      redir = 1'b1;
      case (r)
        0: begin exc_req = 1'b1; rfe_req = $urandom_range(0, 1); tgt = 32'h80; end
        1: begin rfe_req = 1'b1; epc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00}; tgt = epc; end
        2: begin pc_src = 2'b01; branch = {20'h0, 10'($urandom_range(0, 1023)), 2'b00}; tgt = branch; end
        3: begin pc_src = 2'b10; offset28 = {16'h0, 10'($urandom_range(0, 1023)), 2'b00}; tgt = {4'h0, offset28}; end
        4: begin pc_src = 2'b11; rs = {20'h0, 10'($urandom_range(0, 1023)), 2'b00}; tgt = rs; end
        default: begin redir = 1'b0; tgt = '0; end
      endcase

      if (ins_valid && !id_stall) begin
        chk("r_pc", pc_out, exp_pc);
        chk("r_ins", ins_out, mem_word(exp_pc));
        chk("r_vec", vector_if, 0);
        exp_pc = exp_pc + 32'd4;
        n_cons++;
      end
      if (redir) exp_pc = tgt;

      prev_hold  = ins_valid && id_stall && !redir;
      prev_ins   = ins_out;
      prev_pc    = pc_out;
      prev_vec   = vector_if;
      prev_redir = redir;
      prev_pend  = imem_req && !imem_ack;
      prev_addr  = imem_addr;
    end
    clear_redirects();
    id_stall = 1'b0;
    chk("r_progress", (n_cons >= 200), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
